// File: rtl/gemm_tile_seq_if.sv
// Control/handshake bundle between the GEMM tile sequencer and its phase
// counter, PE array strobes and buffer address ports.
interface gemm_tile_seq_if #(
    parameter int CNT_WIDTH  = 4,
    parameter int TILE_WIDTH = 2
);
    logic                            start_i;
    logic                            stall_i;
    logic [CNT_WIDTH-1:0]            cnt_i;
    logic                            is_done_1_i;
    logic                            is_done_2_i;
    logic                            cnt_en_o;
    logic                            cnt_sel_o;
    logic                            w_load_o;
    logic [CNT_WIDTH+TILE_WIDTH-1:0] w_rd_addr_o;
    logic                            a_feed_o;
    logic [CNT_WIDTH+TILE_WIDTH-1:0] a_rd_addr_o;
    logic [TILE_WIDTH-1:0]           tile_idx_o;
    logic                            busy_o;
    logic                            done_o;

    modport master (
        output start_i, stall_i, cnt_i, is_done_1_i, is_done_2_i,
        input  cnt_en_o, cnt_sel_o, w_load_o, w_rd_addr_o, a_feed_o,
               a_rd_addr_o, tile_idx_o, busy_o, done_o
    );

    modport slave (
        input  start_i, stall_i, cnt_i, is_done_1_i, is_done_2_i,
        output cnt_en_o, cnt_sel_o, w_load_o, w_rd_addr_o, a_feed_o,
               a_rd_addr_o, tile_idx_o, busy_o, done_o
    );
endinterface

// File: rtl/gemm_tile_seq.sv
// GEMM tile sequencer: per tile, loads weights, feeds activations, then
// drains the systolic array; repeats for NUM_TILES tiles and pulses done_o.
//
// state | meaning
// IDLE  | waiting for start_i
// LOAD  | weight load, phase counter in LOAD-length mode
// FEED  | activation feed, phase counter in FEED-length mode
// DRAIN | array flush, internal down-counter runs DRAIN_CYC cycles
// DONE  | one-cycle done_o pulse, then back to IDLE
module gemm_tile_seq #(
    parameter int CNT_1      = 14,
    parameter int CNT_2      = 8,
    parameter int CNT_WIDTH  = 4,
    parameter int NUM_TILES  = 4,
    parameter int TILE_WIDTH = 2,
    parameter int DRAIN_CYC  = 4
) (
    input logic             clk,
    input logic             rst_n,
    gemm_tile_seq_if.slave  bus
);

    localparam int DRAIN_W = 4;
    localparam logic [TILE_WIDTH-1:0] LAST_TILE  = TILE_WIDTH'(NUM_TILES - 1);
    localparam logic [DRAIN_W-1:0]    DRAIN_INIT = DRAIN_W'(DRAIN_CYC - 1);

    if (CNT_1 < 1 || CNT_1 > 2**CNT_WIDTH || CNT_2 < 1 || CNT_2 > 2**CNT_WIDTH) begin : g_bad_cnt
        $error("gemm_tile_seq: phase lengths do not fit the counter width");
    end
    if (NUM_TILES < 1 || NUM_TILES > 2**TILE_WIDTH || DRAIN_CYC < 1 || DRAIN_CYC > 16) begin : g_bad_range
        $error("gemm_tile_seq: NUM_TILES or DRAIN_CYC out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [TILE_WIDTH-1:0] tile_q, tile_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic                  phase_run;

    always_comb begin
        state_d = state_q;
        tile_d  = tile_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_LOAD;
                    tile_d  = '0;
                end
            end
            ST_LOAD: begin
                if (bus.is_done_2_i) state_d = ST_FEED;
            end
            ST_FEED: begin
                if (bus.is_done_1_i) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            ST_DRAIN: begin
                // The drain counter only moves on non-stalled cycles.
                if (!bus.stall_i) begin
                    if (drain_q == '0) begin
                        if (tile_q == LAST_TILE) begin
                            state_d = ST_DONE;
                        end else begin
                            tile_d  = tile_q + 1'b1;
                            state_d = ST_LOAD;
                        end
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tile_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            tile_q  <= tile_d;
            drain_q <= drain_d;
        end
    end

    assign phase_run       = ((state_q == ST_LOAD) || (state_q == ST_FEED)) && !bus.stall_i;
    assign bus.cnt_en_o    = phase_run;
    assign bus.cnt_sel_o   = (state_q == ST_LOAD);
    assign bus.w_load_o    = phase_run && (state_q == ST_LOAD);
    assign bus.a_feed_o    = phase_run && (state_q == ST_FEED);
    assign bus.w_rd_addr_o = {tile_q, bus.cnt_i};
    assign bus.a_rd_addr_o = {tile_q, bus.cnt_i};
    assign bus.tile_idx_o  = tile_q;
    assign bus.busy_o      = (state_q != ST_IDLE);
    assign bus.done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_gemm_tile_seq.sv
// Scoreboard bench for gemm_tile_seq: models the external phase counter,
// queues expected addresses and job lengths, and compares on DUT output.
module tb_gemm_tile_seq;
    localparam int CNT_1     = 14;
    localparam int CNT_2     = 8;
    localparam int CNT_W     = 4;
    localparam int TILE_W    = 2;
    localparam int NUM_TILES = 4;
    localparam int DRAIN_CYC = 4;
    localparam int JOB_CYC   = NUM_TILES * (CNT_2 + CNT_1 + DRAIN_CYC) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gemm_tile_seq_if #(.CNT_WIDTH(CNT_W), .TILE_WIDTH(TILE_W)) bus ();
    gemm_tile_seq_if #(.CNT_WIDTH(CNT_W), .TILE_WIDTH(TILE_W)) bus1 ();

    gemm_tile_seq #(
        .CNT_1(CNT_1), .CNT_2(CNT_2), .CNT_WIDTH(CNT_W),
        .NUM_TILES(NUM_TILES), .TILE_WIDTH(TILE_W), .DRAIN_CYC(DRAIN_CYC)
    ) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    gemm_tile_seq #(
        .CNT_1(CNT_1), .CNT_2(CNT_2), .CNT_WIDTH(CNT_W),
        .NUM_TILES(1), .TILE_WIDTH(TILE_W), .DRAIN_CYC(1)
    ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    function automatic logic [CNT_W-1:0] term(input logic sel);
        return sel ? CNT_W'(CNT_2 - 1) : CNT_W'(CNT_1 - 1);
    endfunction

    // External phase counter models, sharing rst_n with the DUTs.
    logic [CNT_W-1:0] cnt_q, cnt1_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               cnt_q <= '0;
        else if (bus.cnt_en_o)    cnt_q <= (cnt_q == term(bus.cnt_sel_o)) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               cnt1_q <= '0;
        else if (bus1.cnt_en_o)   cnt1_q <= (cnt1_q == term(bus1.cnt_sel_o)) ? '0 : cnt1_q + 1'b1;
    end
    assign bus.cnt_i        = cnt_q;
    assign bus.is_done_1_i  = bus.cnt_en_o && !bus.cnt_sel_o && (cnt_q == term(1'b0));
    assign bus.is_done_2_i  = bus.cnt_en_o &&  bus.cnt_sel_o && (cnt_q == term(1'b1));
    assign bus1.cnt_i       = cnt1_q;
    assign bus1.is_done_1_i = bus1.cnt_en_o && !bus1.cnt_sel_o && (cnt1_q == term(1'b0));
    assign bus1.is_done_2_i = bus1.cnt_en_o &&  bus1.cnt_sel_o && (cnt1_q == term(1'b1));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    int                      done_q[$];
    logic [CNT_W+TILE_W-1:0] w_q[$];
    logic [CNT_W+TILE_W-1:0] a_q[$];
    int busy_cnt  = 0;
    int n_done    = 0;
    int busy1_cnt = 0;
    int n_done1   = 0;

    task automatic push_job(input int extra);
        done_q.push_back(JOB_CYC + extra);
        for (int t = 0; t < NUM_TILES; t++) begin
            for (int k = 0; k < CNT_2; k++) w_q.push_back((CNT_W+TILE_W)'(t * 16 + k));
            for (int k = 0; k < CNT_1; k++) a_q.push_back((CNT_W+TILE_W)'(t * 16 + k));
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy_o) busy_cnt++;
            if (bus.w_load_o) begin
                if (w_q.size() == 0) chk("w_extra", 1, 0);
                else                 chk("w_addr", int'(bus.w_rd_addr_o), int'(w_q.pop_front()));
            end
            if (bus.a_feed_o) begin
                if (a_q.size() == 0) chk("a_extra", 1, 0);
                else                 chk("a_addr", int'(bus.a_rd_addr_o), int'(a_q.pop_front()));
            end
            if (bus.done_o) begin
                if (done_q.size() == 0) chk("done_extra", 1, 0);
                else                    chk("job_cycles", busy_cnt, done_q.pop_front());
                busy_cnt = 0;
                n_done++;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            busy1_cnt = 0;
        end else begin
            if (bus1.busy_o) busy1_cnt++;
            if (bus1.done_o) begin
                chk("single_tile_cycles", busy1_cnt, 24);
                busy1_cnt = 0;
                n_done1++;
            end
        end
    end

    task automatic wait_jobs(input int target, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk); #3;
            if (n_done >= target) return;
        end
        chk("job_timeout", n_done, target);
    endtask

    task automatic wait_feed(input int tile, input int cnt, output bit found);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (bus.a_feed_o && int'(bus.tile_idx_o) == tile && int'(bus.cnt_i) == cnt) begin
                found = 1'b1;
                return;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},   int'(bus.busy_o),     0);
        chk({tag, "_done"},   int'(bus.done_o),     0);
        chk({tag, "_cnt_en"}, int'(bus.cnt_en_o),   0);
        chk({tag, "_w_load"}, int'(bus.w_load_o),   0);
        chk({tag, "_a_feed"}, int'(bus.a_feed_o),   0);
        chk({tag, "_tile"},   int'(bus.tile_idx_o), 0);
    endtask

    initial begin
        bit found;
        bus.start_i  = 1'b0;
        bus.stall_i  = 1'b0;
        bus1.start_i = 1'b0;
        bus1.stall_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("rst");

        // Basic job; start is presented as reset releases, so the first edge must take it.
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus1.start_i = 1'b1;
        push_job(0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_edge_busy", int'(bus.busy_o), 1);
        chk("first_edge_sel",  int'(bus.cnt_sel_o), 1);
        @(negedge clk);
        bus.start_i  = 1'b0;
        bus1.start_i = 1'b0;
        wait_jobs(1, 200);
        chk("single_tile_jobs", n_done1, 1);
        @(negedge clk); #3;
        chk("busy_falls", int'(bus.busy_o), 0);

        // Three-cycle stall mid-FEED at cnt_i=5.
        @(negedge clk);
        bus.start_i = 1'b1;
        push_job(3);
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_feed(1, 5, found);
        chk("stall_point_found", int'(found), 1);
        bus.stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("stall_cnt_en", int'(bus.cnt_en_o), 0);
            chk("stall_a_feed", int'(bus.a_feed_o), 0);
            chk("stall_cnt_hold", int'(bus.cnt_i), 5);
            chk("stall_busy", int'(bus.busy_o), 1);
            @(negedge clk); #1;
        end
        bus.stall_i = 1'b0;
        wait_jobs(2, 300);

        // start_i held through a whole job: one completion, then a fresh job.
        @(negedge clk);
        bus.start_i = 1'b1;
        push_job(0);
        push_job(0);
        wait_jobs(3, 300);
        @(negedge clk); #1;
        chk("after_done_idle", int'(bus.busy_o), 0);
        @(negedge clk); #1;
        chk("restart_busy", int'(bus.busy_o), 1);
        chk("restart_load", int'(bus.w_load_o), 1);
        bus.start_i = 1'b0;
        wait_jobs(4, 300);

        // Reset during tile 1 FEED aborts the job without a done pulse.
        @(negedge clk);
        bus.start_i = 1'b1;
        push_job(0);
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_feed(1, 3, found);
        chk("reset_point_found", int'(found), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        done_q.delete();
        w_q.delete();
        a_q.delete();
        repeat (3) @(negedge clk);
        chk("midrst_no_done", n_done, 4);
        bus.start_i = 1'b1;
        push_job(0);
        rst_n = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_jobs(5, 300);

        repeat (3) @(negedge clk);
        chk("done_q_empty", done_q.size(), 0);
        chk("w_q_empty", w_q.size(), 0);
        chk("a_q_empty", a_q.size(), 0);
        chk("single_tile_total", n_done1, 1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
